// File: rtl/std_seq_delay.sv
// Valid/data shift register used to stretch the read pipeline.
// Data in each stage only moves when a valid word arrives, so the tail holds.
module std_seq_delay #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;

    always_comb begin
        valid_d    = '0;
        data_d     = data_q;
        valid_d[0] = in_valid;
        if (in_valid) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/std_seq_mem_d1.sv
// Single-port 1-D memory with registered, pipelined reads.
// Read-before-write on a shared address; out-of-range reads return 0.
module std_seq_mem_d1 #(
    parameter int WIDTH        = 32,
    parameter int SIZE         = 16,
    parameter int IDX_SIZE     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    write_data,
    input  logic                write_en,
    input  logic                read_en,
    output logic [WIDTH-1:0]    read_data,
    output logic                read_done,
    output logic                write_done
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("std_seq_mem_d1: READ_LATENCY must be 1..4");
    end
    if ((2 ** IDX_SIZE) < SIZE) begin : g_bad_idx
        $error("std_seq_mem_d1: IDX_SIZE too small for SIZE");
    end

    logic [WIDTH-1:0] mem_q [SIZE];

    logic             in_range;
    logic [WIDTH-1:0] rd_word;

    logic             s0_valid_q;
    logic             s0_valid_d;
    logic [WIDTH-1:0] s0_data_q;
    logic [WIDTH-1:0] s0_data_d;
    logic             wr_done_q;
    logic             wr_done_d;

    assign in_range = 32'(addr0) < SIZE;

    always_comb begin
        rd_word    = '0;
        s0_valid_d = read_en;
        s0_data_d  = s0_data_q;
        wr_done_d  = write_en;
        if (in_range) begin
            rd_word = mem_q[addr0];
        end
        if (read_en) begin
            s0_data_d = rd_word;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && write_en && in_range) begin
            mem_q[addr0] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_data_q  <= s0_data_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign write_done = wr_done_q;

    if (READ_LATENCY > 1) begin : g_pipe
        std_seq_delay #(
            .WIDTH (WIDTH),
            .DEPTH (READ_LATENCY - 1)
        ) u_delay (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (s0_valid_q),
            .in_data   (s0_data_q),
            .out_valid (read_done),
            .out_data  (read_data)
        );
    end else begin : g_direct
        assign read_done = s0_valid_q;
        assign read_data = s0_data_q;
    end

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Randomized bench for std_seq_mem_d1 over several latency/size configs.
// A per-config array model schedules completions by cycle number.
module tb_std_seq_mem_d1;

    localparam int N    = 4;
    localparam int MAXC = 1400;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] rd  [N];
    logic       rdn [N];
    logic       wdn [N];

    always #5 clk = ~clk;

    std_seq_mem_d1 #(.WIDTH(8), .SIZE(16), .IDX_SIZE(4), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .addr0(addr), .write_data(wd),
        .write_en(we), .read_en(re), .read_data(rd[0]),
        .read_done(rdn[0]), .write_done(wdn[0])
    );
    std_seq_mem_d1 #(.WIDTH(8), .SIZE(16), .IDX_SIZE(4), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .addr0(addr), .write_data(wd),
        .write_en(we), .read_en(re), .read_data(rd[1]),
        .read_done(rdn[1]), .write_done(wdn[1])
    );
    std_seq_mem_d1 #(.WIDTH(8), .SIZE(16), .IDX_SIZE(4), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .addr0(addr), .write_data(wd),
        .write_en(we), .read_en(re), .read_data(rd[2]),
        .read_done(rdn[2]), .write_done(wdn[2])
    );
    std_seq_mem_d1 #(.WIDTH(8), .SIZE(12), .IDX_SIZE(4), .READ_LATENCY(2)) u_s12 (
        .clk(clk), .reset(reset), .addr0(addr), .write_data(wd),
        .write_en(we), .read_en(re), .read_data(rd[3]),
        .read_done(rdn[3]), .write_done(wdn[3])
    );

    int lat [N] = '{1, 2, 4, 2};
    int sz  [N] = '{16, 16, 16, 12};

    logic [7:0] mem_m [N][16];
    bit         pv    [N][MAXC];
    logic [7:0] pd    [N][MAXC];
    logic [7:0] exp_d [N];
    bit         exp_v [N];
    bit         exp_w [N];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rr,
                        input logic [3:0] a, input logic [7:0] d);
        reset = r;
        we    = w;
        re    = rr;
        addr  = a;
        wd    = d;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (r) begin
                for (int j = cyc; j < cyc + 5; j++) pv[k][j] = 1'b0;
                exp_d[k] = 8'h00;
                exp_v[k] = 1'b0;
                exp_w[k] = 1'b0;
            end else begin
                if (rr) begin
                    int t;
                    t = cyc + lat[k] - 1;
                    pv[k][t] = 1'b1;
                    pd[k][t] = (int'(a) < sz[k]) ? mem_m[k][a] : 8'h00;
                end
                if (w && int'(a) < sz[k]) mem_m[k][a] = d;
                exp_w[k] = w;
                exp_v[k] = pv[k][cyc];
                if (exp_v[k]) exp_d[k] = pd[k][cyc];
            end
        end
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("wdone%0d", k), 32'(wdn[k]), 32'(exp_w[k]));
            check($sformatf("rdone%0d", k), 32'(rdn[k]), 32'(exp_v[k]));
            check($sformatf("rdata%0d", k), 32'(rd[k]), 32'(exp_d[k]));
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_d[k] = 8'h00;
            exp_v[k] = 1'b0;
            exp_w[k] = 1'b0;
            for (int j = 0; j < MAXC; j++) pv[k][j] = 1'b0;
        end
        step(1, 1, 1, 4'h0, 8'h00);
        step(1, 0, 0, 4'h0, 8'h00);
        for (int a = 0; a < 16; a++) step(0, 1, 0, 4'(a), 8'(a * 3 + 1));
        idle(1);
        step(0, 1, 0, 4'd3, 8'hA5);
        idle(1);
        step(0, 0, 1, 4'd3, 8'h00);
        idle(5);
        for (int a = 0; a < 4; a++) step(0, 1, 0, 4'(a), 8'(8'h11 + a));
        for (int a = 0; a < 4; a++) step(0, 0, 1, 4'(a), 8'h00);
        idle(6);
        step(0, 1, 0, 4'd5, 8'h22);
        step(0, 1, 1, 4'd5, 8'h77);
        step(0, 0, 1, 4'd5, 8'h00);
        idle(5);
        step(0, 1, 0, 4'd7, 8'h3C);
        step(0, 0, 1, 4'd7, 8'h00);
        step(0, 0, 1, 4'd6, 8'h00);
        step(1, 1, 1, 4'd7, 8'hEE);
        idle(5);
        step(0, 0, 1, 4'd7, 8'h00);
        idle(5);
        step(0, 1, 0, 4'd13, 8'h55);
        step(0, 0, 1, 4'd13, 8'h00);
        for (int a = 0; a < 12; a++) step(0, 0, 1, 4'(a), 8'h00);
        idle(6);
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 6,
                 4'($urandom_range(0, 15)),
                 8'($urandom));
        end
        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
